jtdd_mcu_hostif: RTL and testbench

- Main-CPU-side end of the main/MCU link: decodes the main CPU's accesses to the shared RAM window and to the MCU control registers.
- Drives com_cs, mcu_nmi_set and mcu_halt towards the MCU block.
- Stalls the main CPU while the MCU owns the bus (mcu_ban).
- Latches the MCU's mcu_irqmain request into an acknowledgeable main-CPU interrupt.
- Sits between the main CPU core and the MCU block in the game top level.

---
 rtl/jtdd_pkg.sv | 35 +++
 rtl/jtdd_mcu_arb.sv | 101 ++++++++++
 rtl/jtdd_mcu_hostif.sv | 119 +++++++++++
 tb/tb_jtdd_mcu_hostif.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_pkg.sv
// ---------------------------------------------------------------------------
// jtdd_pkg
// Shared constants and types for the main-CPU side of the main/MCU link.
//   - Address map of the shared RAM window and the MCU control registers
//   - NMI pulse length and the stall limit before a forced bus grant
//   - Arbiter state encoding
//   - is_shared(): page compare for the 512-byte shared RAM window
// ---------------------------------------------------------------------------
package jtdd_pkg;

  // Address map seen by the main CPU
  localparam logic [15:0] SH_BASE   = 16'h2000;
  localparam logic [15:0] CTRL_ADDR = 16'h380B;
  localparam logic [15:0] NMI_ADDR  = 16'h380C;
  localparam logic [15:0] IACK_ADDR = 16'h380D;

  // Timing constants, in clk cycles
  localparam int NMI_LEN = 4;
  localparam int MAXWAIT = 1023;

  localparam int NMI_CW  = $clog2(NMI_LEN + 1);
  localparam int WAIT_CW = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_GRANT = 2'd2
  } arb_state_t;

  // The window is 512 bytes, so only A[15:9] take part in the decode
  function automatic logic is_shared(input logic [6:0] page);
    return page == SH_BASE[15:9];
  endfunction

endpackage

// File: rtl/jtdd_mcu_arb.sv
// ---------------------------------------------------------------------------
// jtdd_mcu_arb
// Arbitrates the main CPU's access to the shared RAM against the MCU.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   cen_E       main CPU clock enable (one pulse per E cycle)
//   sh_req      main CPU is addressing the shared window this cycle
//   mcu_ban     MCU currently owns the shared bus
//   com_cs      shared RAM chip select for the main CPU access
//   cpu_wait    stall request towards the main CPU clock enable
//   timeout     sticky flag: a grant was forced after MAXWAIT stall cycles
// ---------------------------------------------------------------------------
module jtdd_mcu_arb
  import jtdd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cen_E,
  input  logic sh_req,
  input  logic mcu_ban,
  output logic com_cs,
  output logic cpu_wait,
  output logic timeout
);

  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(MAXWAIT - 1);

  arb_state_t         state_q, state_d;
  logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
  logic               ban_low_q, ban_low_d;
  logic               timeout_q, timeout_d;
  logic               fast_grant;
  logic               granted;

  // A free bus in IDLE is granted within the same clk, so the access
  // behaves as if the FSM were already in GRANT. If the CPU's cen_E lands
  // in that very cycle the access is complete and the FSM never leaves IDLE.
  // The wait counter counts stall cycles, including the IDLE cycle in which
  // the stall starts, so cpu_wait is high for at most MAXWAIT cycles.
  always_comb begin
    fast_grant = (state_q == ARB_IDLE) & sh_req & ~mcu_ban;
    granted    = (state_q == ARB_GRANT) | fast_grant;
    state_d    = state_q;
    wait_cnt_d = '0;
    ban_low_d  = 1'b0;
    timeout_d  = timeout_q;
    case (state_q)
      ARB_IDLE: begin
        if (sh_req) begin
          if (mcu_ban) begin
            state_d    = ARB_WAIT;
            wait_cnt_d = WAIT_CW'(1);
          end else if (!cen_E) begin
            state_d = ARB_GRANT;
          end
        end
      end
      ARB_WAIT: begin
        if (!sh_req) begin
          state_d = ARB_IDLE;
        end else if (!mcu_ban && ban_low_q) begin
          state_d = ARB_GRANT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ARB_GRANT;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
          ban_low_d  = ~mcu_ban;
        end
      end
      ARB_GRANT: begin
        if (cen_E || !sh_req) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      wait_cnt_q <= '0;
      ban_low_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ban_low_q  <= ban_low_d;
      timeout_q  <= timeout_d;
    end
  end

  // Both outputs depend on live inputs, so they are masked by rst to drop
  // immediately when reset is asserted mid-access.
  assign com_cs   = ~rst & granted & sh_req;
  assign cpu_wait = ~rst & ((state_q == ARB_WAIT) |
                            ((state_q == ARB_IDLE) & sh_req & mcu_ban));
  assign timeout  = timeout_q;

endmodule

// File: rtl/jtdd_mcu_hostif.sv
// ---------------------------------------------------------------------------
// jtdd_mcu_hostif
// Main-CPU-side end of the main/MCU link.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   cen_E         main CPU clock enable
//   cpu_AB/rnw/vma/dout   main CPU bus
//   shared_dout   shared RAM read data from the MCU block
//   mcu_ban       MCU owns the shared bus
//   mcu_irqmain   MCU interrupt request level
//   com_cs        shared RAM chip select towards the MCU block
//   mcu_nmi_set   NMI_LEN-cycle NMI trigger pulse to the MCU
//   mcu_halt      MCU halt, bit 0 of the control register
//   cpu_wait      stall; the top level gates the CPU cen with ~cpu_wait
//   cpu_din       read data: shared_dout inside the window, 8'hFF elsewhere
//   main_irq      latched MCU interrupt towards the main CPU
//   timeout       sticky: a forced grant occurred
// ---------------------------------------------------------------------------
module jtdd_mcu_hostif
  import jtdd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen_E,
  input  logic [15:0] cpu_AB,
  input  logic        cpu_rnw,
  input  logic        cpu_vma,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  shared_dout,
  input  logic        mcu_ban,
  input  logic        mcu_irqmain,
  output logic        com_cs,
  output logic        mcu_nmi_set,
  output logic        mcu_halt,
  output logic        cpu_wait,
  output logic [7:0]  cpu_din,
  output logic        main_irq,
  output logic        timeout
);

  logic              sh_hit;
  logic              sh_req;
  logic              reg_wr;
  logic              ctrl_wr;
  logic              nmi_wr;
  logic              iack_wr;
  logic              irq_rise;
  logic              halt_q, halt_d;
  logic [NMI_CW-1:0] nmi_cnt_q, nmi_cnt_d;
  logic              irq_in_q, irq_in_d;
  logic              main_irq_q, main_irq_d;
  logic              unused_dout;

  assign sh_hit   = is_shared(cpu_AB[15:9]);
  assign sh_req   = cpu_vma & sh_hit;
  assign reg_wr   = cpu_vma & ~cpu_rnw & cen_E;
  assign ctrl_wr  = reg_wr & (cpu_AB == CTRL_ADDR);
  assign nmi_wr   = reg_wr & (cpu_AB == NMI_ADDR);
  assign iack_wr  = reg_wr & (cpu_AB == IACK_ADDR);
  assign irq_rise = mcu_irqmain & ~irq_in_q;

  // Only bit 0 of the write data is meaningful on this bus
  assign unused_dout = &{1'b0, cpu_dout[7:1]};

  jtdd_mcu_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .cen_E    (cen_E),
    .sh_req   (sh_req),
    .mcu_ban  (mcu_ban),
    .com_cs   (com_cs),
    .cpu_wait (cpu_wait),
    .timeout  (timeout)
  );

  // A retrigger reloads the NMI counter instead of restarting it, so the
  // pulse simply stretches with no low gap; the MCU only sees one edge.
  // For the IRQ latch a new edge beats a simultaneous acknowledge so that
  // request is never lost.
  always_comb begin
    halt_d     = halt_q;
    nmi_cnt_d  = nmi_cnt_q;
    irq_in_d   = mcu_irqmain;
    main_irq_d = main_irq_q;
    if (ctrl_wr) begin
      halt_d = cpu_dout[0];
    end
    if (nmi_wr) begin
      nmi_cnt_d = NMI_CW'(NMI_LEN);
    end else if (nmi_cnt_q != '0) begin
      nmi_cnt_d = nmi_cnt_q - NMI_CW'(1);
    end
    if (irq_rise) begin
      main_irq_d = 1'b1;
    end else if (iack_wr) begin
      main_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q     <= 1'b0;
      nmi_cnt_q  <= '0;
      irq_in_q   <= 1'b0;
      main_irq_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      nmi_cnt_q  <= nmi_cnt_d;
      irq_in_q   <= irq_in_d;
      main_irq_q <= main_irq_d;
    end
  end

  assign mcu_halt    = halt_q;
  assign mcu_nmi_set = (nmi_cnt_q != '0);
  assign main_irq    = main_irq_q;
  assign cpu_din     = sh_hit ? shared_dout : 8'hFF;

endmodule

// File: tb/tb_jtdd_mcu_hostif.sv
// ---------------------------------------------------------------------------
// tb_jtdd_mcu_hostif
// Directed bench for jtdd_mcu_hostif: a vector table stepped one clk per
// row, followed by hand-written multi-cycle sequences (NMI retrigger, bus
// stall release, reset during a stall, forced grant on timeout).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_jtdd_mcu_hostif;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen_E;
  logic [15:0] cpu_AB;
  logic        cpu_rnw;
  logic        cpu_vma;
  logic [7:0]  cpu_dout;
  logic [7:0]  shared_dout;
  logic        mcu_ban;
  logic        mcu_irqmain;
  logic        com_cs;
  logic        mcu_nmi_set;
  logic        mcu_halt;
  logic        cpu_wait;
  logic [7:0]  cpu_din;
  logic        main_irq;
  logic        timeout;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [15:0] ab;
    logic        rnw;
    logic        vma;
    logic        cen;
    logic [7:0]  dout;
    logic [7:0]  sd;
    logic        ban;
    logic        irq;
    logic        exp_com;
    logic        exp_wait;
    logic [7:0]  exp_din;
    logic        exp_nmi;
    logic        exp_halt;
    logic        exp_mirq;
  } vec_t;

  vec_t vecs[$];

  jtdd_mcu_hostif dut (
    .clk         (clk),
    .rst         (rst),
    .cen_E       (cen_E),
    .cpu_AB      (cpu_AB),
    .cpu_rnw     (cpu_rnw),
    .cpu_vma     (cpu_vma),
    .cpu_dout    (cpu_dout),
    .shared_dout (shared_dout),
    .mcu_ban     (mcu_ban),
    .mcu_irqmain (mcu_irqmain),
    .com_cs      (com_cs),
    .mcu_nmi_set (mcu_nmi_set),
    .mcu_halt    (mcu_halt),
    .cpu_wait    (cpu_wait),
    .cpu_din     (cpu_din),
    .main_irq    (main_irq),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_count(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ab, input logic rnw, input logic vma,
                              input logic cen, input logic [7:0] dout, input logic [7:0] sd,
                              input logic ban, input logic irq, input logic e_com,
                              input logic e_wait, input logic [7:0] e_din, input logic e_nmi,
                              input logic e_halt, input logic e_mirq);
    vec_t v;
    v.ab = ab; v.rnw = rnw; v.vma = vma; v.cen = cen; v.dout = dout; v.sd = sd;
    v.ban = ban; v.irq = irq; v.exp_com = e_com; v.exp_wait = e_wait; v.exp_din = e_din;
    v.exp_nmi = e_nmi; v.exp_halt = e_halt; v.exp_mirq = e_mirq;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    cpu_AB      = v.ab;
    cpu_rnw     = v.rnw;
    cpu_vma     = v.vma;
    cen_E       = v.cen;
    cpu_dout    = v.dout;
    shared_dout = v.sd;
    mcu_ban     = v.ban;
    mcu_irqmain = v.irq;
  endtask

  task automatic set_idle();
    cpu_AB   = 16'h0000;
    cpu_rnw  = 1'b1;
    cpu_vma  = 1'b0;
    cen_E    = 1'b0;
    cpu_dout = 8'h00;
    mcu_ban  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_AB   = addr;
    cpu_dout = data;
    cpu_rnw  = 1'b0;
    cpu_vma  = 1'b1;
    cen_E    = 1'b1;
    next_cycle();
    set_idle();
  endtask

  initial begin
    int stall;
    int leak;
    bit done;

    // Table rows: ab, rnw, vma, cen, dout, sd, ban, irq | com, wait, din, nmi, halt, mirq
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 0 idle
    vecs.push_back(mk(16'h2010,1,1,0,8'h00,8'h3C,0,0, 1,0,8'h3C,0,0,0)); // 1 read, free bus
    vecs.push_back(mk(16'h2010,1,1,1,8'h00,8'h3C,0,0, 1,0,8'h3C,0,0,0)); // 2 GRANT, cen ends it
    vecs.push_back(mk(16'h2010,0,1,1,8'h5A,8'h3C,0,0, 1,0,8'h3C,0,0,0)); // 3 write 5A same-cycle
    vecs.push_back(mk(16'h2010,0,1,0,8'h5A,8'h3C,1,0, 0,1,8'h3C,0,0,0)); // 4 back in IDLE: stall
    vecs.push_back(mk(16'h2010,0,0,0,8'h5A,8'h3C,1,0, 0,1,8'h3C,0,0,0)); // 5 WAIT, vma drops
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,1,0, 0,0,8'hFF,0,0,0)); // 6 idle
    vecs.push_back(mk(16'h2010,1,1,0,8'h00,8'h3C,0,0, 1,0,8'h3C,0,0,0)); // 7 fast grant
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 8 sh_req falls
    vecs.push_back(mk(16'h380B,0,1,1,8'h01,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 9 CTRL <= 01
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,1,0)); // 10
    vecs.push_back(mk(16'h380B,0,1,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,1,0)); // 11 no cen_E
    vecs.push_back(mk(16'h380B,0,0,1,8'h00,8'h3C,0,0, 0,0,8'hFF,0,1,0)); // 12 no vma
    vecs.push_back(mk(16'h380B,1,1,1,8'h00,8'h3C,0,0, 0,0,8'hFF,0,1,0)); // 13 read
    vecs.push_back(mk(16'h380B,0,1,1,8'h00,8'h3C,0,0, 0,0,8'hFF,0,1,0)); // 14 CTRL <= 00
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 15
    vecs.push_back(mk(16'h380C,0,1,1,8'h00,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 16 NMI write
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,1,0,0)); // 17..20 pulse
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 21 pulse over
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,0)); // 22 irq rises
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,1)); // 23 latched
    vecs.push_back(mk(16'h380D,0,1,1,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,1)); // 24 IACK
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,0)); // 25 level ignored
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,0)); // 26
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,0, 0,0,8'hFF,0,0,0)); // 27 irq low
    vecs.push_back(mk(16'h380D,0,1,1,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,0)); // 28 edge + IACK
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,1)); // 29 set wins
    vecs.push_back(mk(16'h380D,0,1,1,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,1)); // 30 IACK alone
    vecs.push_back(mk(16'h0000,1,0,0,8'h00,8'h3C,0,1, 0,0,8'hFF,0,0,0)); // 31 cleared
    vecs.push_back(mk(16'h21FF,1,0,0,8'h00,8'hA7,0,0, 0,0,8'hA7,0,0,0)); // 32 window top
    vecs.push_back(mk(16'h2200,1,1,0,8'h00,8'hA7,0,0, 0,0,8'hFF,0,0,0)); // 33 above window
    vecs.push_back(mk(16'h1FFF,1,1,0,8'h00,8'hA7,0,0, 0,0,8'hFF,0,0,0)); // 34 below window

    // Reset state
    rst = 1'b1;
    set_idle();
    shared_dout = 8'h3C;
    mcu_irqmain = 1'b0;
    #2;
    check_output("rst_com_cs", com_cs, 1'b0);
    check_output("rst_nmi", mcu_nmi_set, 1'b0);
    check_output("rst_halt", mcu_halt, 1'b0);
    check_output("rst_wait", cpu_wait, 1'b0);
    check_output("rst_main_irq", main_irq, 1'b0);
    check_output("rst_timeout", timeout, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Table-driven vectors, one clk per row
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("vec%0d.com_cs", i), com_cs, vecs[i].exp_com);
      check_output($sformatf("vec%0d.cpu_wait", i), cpu_wait, vecs[i].exp_wait);
      check_byte($sformatf("vec%0d.cpu_din", i), cpu_din, vecs[i].exp_din);
      check_output($sformatf("vec%0d.nmi", i), mcu_nmi_set, vecs[i].exp_nmi);
      check_output($sformatf("vec%0d.halt", i), mcu_halt, vecs[i].exp_halt);
      check_output($sformatf("vec%0d.main_irq", i), main_irq, vecs[i].exp_mirq);
      next_cycle();
    end
    set_idle();
    mcu_irqmain = 1'b0;
    next_cycle();

    // NMI retrigger two clk after the first write: high 6 clk, no gap
    reg_write(NMI_ADDR_TB, 8'h00);
    @(negedge clk);
    check_output("nmi_retrig_c1", mcu_nmi_set, 1'b1);
    next_cycle();
    cpu_AB = NMI_ADDR_TB; cpu_rnw = 1'b0; cpu_vma = 1'b1; cen_E = 1'b1;
    @(negedge clk);
    check_output("nmi_retrig_c2", mcu_nmi_set, 1'b1);
    next_cycle();
    set_idle();
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      check_output($sformatf("nmi_retrig_c%0d", c), mcu_nmi_set, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    check_output("nmi_retrig_c7", mcu_nmi_set, 1'b0);
    next_cycle();

    // Shared read with mcu_ban high for 20 clk then low
    shared_dout = 8'h96;
    cpu_AB = 16'h2010; cpu_rnw = 1'b1; cpu_vma = 1'b1; mcu_ban = 1'b1;
    stall = 0;
    leak  = 0;
    done  = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c == 20) mcu_ban = 1'b0;
      @(negedge clk);
      if (cpu_wait) begin
        stall++;
        if (com_cs) leak++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    check_output("ban20_released", done, 1'b1);
    check_count("ban20_stall_cycles", stall, 22);
    check_count("ban20_cs_during_stall", leak, 0);
    check_output("ban20_com_cs", com_cs, 1'b1);
    check_byte("ban20_cpu_din", cpu_din, 8'h96);
    check_output("ban20_timeout", timeout, 1'b0);
    next_cycle();
    cen_E = 1'b1;
    next_cycle();
    set_idle();
    next_cycle();

    // Reset asserted while stalled in WAIT
    reg_write(CTRL_ADDR_TB, 8'h01);
    mcu_irqmain = 1'b1;
    next_cycle();
    mcu_irqmain = 1'b0;
    cpu_AB = 16'h2010; cpu_rnw = 1'b0; cpu_vma = 1'b1; mcu_ban = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("prerst_wait", cpu_wait, 1'b1);
    check_output("prerst_halt", mcu_halt, 1'b1);
    check_output("prerst_main_irq", main_irq, 1'b1);
    next_cycle();
    rst = 1'b1;
    #1;
    check_output("rstwait_cpu_wait", cpu_wait, 1'b0);
    check_output("rstwait_com_cs", com_cs, 1'b0);
    check_output("rstwait_halt", mcu_halt, 1'b0);
    check_output("rstwait_main_irq", main_irq, 1'b0);
    next_cycle();
    set_idle();
    rst = 1'b0;
    next_cycle();

    // mcu_ban held for 1100 clk: forced grant after 1023 stall cycles
    cpu_AB = 16'h2010; cpu_rnw = 1'b0; cpu_vma = 1'b1; mcu_ban = 1'b1;
    stall = 0;
    leak  = 0;
    done  = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      @(negedge clk);
      if (cpu_wait) begin
        stall++;
        if (com_cs) leak++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    check_output("tmo_released", done, 1'b1);
    check_count("tmo_stall_cycles", stall, 1023);
    check_count("tmo_cs_during_stall", leak, 0);
    check_output("tmo_com_cs", com_cs, 1'b1);
    check_output("tmo_flag", timeout, 1'b1);
    next_cycle();
    cen_E = 1'b1;
    next_cycle();
    cpu_vma = 1'b0;
    cen_E   = 1'b0;
    for (int c = 0; c < 80; c++) next_cycle();
    mcu_ban = 1'b0;
    next_cycle();
    @(negedge clk);
    check_output("tmo_sticky", timeout, 1'b1);
    check_output("tmo_idle_wait", cpu_wait, 1'b0);
    next_cycle();
    rst = 1'b1;
    #1;
    check_output("tmo_cleared_by_rst", timeout, 1'b0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  localparam logic [15:0] NMI_ADDR_TB  = 16'h380C;
  localparam logic [15:0] CTRL_ADDR_TB = 16'h380B;

endmodule
